sync_fifo_flags: RTL and testbench

Single-clock, parametrised FIFO with an occupancy count, runtime-programmable almost-full and almost-empty thresholds, and sticky overflow/underflow error flags. FIFO_DEPTH need not be a power of two. Used inside one clock domain, between producer and consumer stages of the LPCS datapath, where the dual-clock synchroniser FIFO is unnecessary. Same request/valid handshake style as the team's dual-clock FIFO.

---
 rtl/sync_fifo_pkg.sv | 17 +
 rtl/fifo_flag_gen.sv | 20 ++
 rtl/sync_fifo_flags.sv | 118 +++++++++++
 tb/tb_sync_fifo_flags.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sync_fifo_pkg.sv
// Shared helpers for the single-clock FIFO family: width helper, wrapping pointer increment, defaults.
package sync_fifo_pkg;

    localparam int DEFAULT_FIFO_WIDTH = 8;
    localparam int DEFAULT_FIFO_DEPTH = 8;

    // Occupancy ranges 0..depth inclusive, so it needs one more code than a pointer.
    function automatic int level_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Explicit wrap so depths that are not a power of two still cycle 0..depth-1.
    function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/fifo_flag_gen.sv
// Combinational status flags derived from a FIFO occupancy count and programmable thresholds.
module fifo_flag_gen #(
    parameter int FIFO_DEPTH  = 8,
    parameter int LEVEL_WIDTH = 4
) (
    input  logic [LEVEL_WIDTH-1:0] level,
    input  logic [LEVEL_WIDTH-1:0] af_thresh,
    input  logic [LEVEL_WIDTH-1:0] ae_thresh,
    output logic                   full,
    output logic                   empty,
    output logic                   almost_full,
    output logic                   almost_empty
);

    assign full         = (level == LEVEL_WIDTH'(FIFO_DEPTH));
    assign empty        = (level == '0);
    assign almost_full  = (level >= af_thresh);
    assign almost_empty = (level <= ae_thresh);

endmodule

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, programmable almost flags and sticky overflow/underflow.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads; default is a registered 1-cycle read.
module sync_fifo_flags
    import sync_fifo_pkg::*;
#(
    parameter int FIFO_WIDTH    = DEFAULT_FIFO_WIDTH,
    parameter int FIFO_DEPTH    = DEFAULT_FIFO_DEPTH,
    parameter int POINTER_WIDTH = $clog2(FIFO_DEPTH),
    parameter int LEVEL_WIDTH   = level_width(FIFO_DEPTH)
) (
    input  logic                   CLK,
    input  logic                   rst_n,
    input  logic [FIFO_WIDTH-1:0]  D_IN,
    input  logic                   Wr_Req,
    input  logic                   Rd_Req,
    input  logic [LEVEL_WIDTH-1:0] AF_Thresh,
    input  logic [LEVEL_WIDTH-1:0] AE_Thresh,
    input  logic                   Clr_Err,
    output logic [FIFO_WIDTH-1:0]  D_OUT,
    output logic                   TX_D_Valid,
    output logic                   Full,
    output logic                   Empty,
    output logic                   Almost_Full,
    output logic                   Almost_Empty,
    output logic [LEVEL_WIDTH-1:0] Level,
    output logic                   Overflow,
    output logic                   Underflow
);

    logic [FIFO_WIDTH-1:0]    mem [FIFO_DEPTH];
    logic [POINTER_WIDTH-1:0] wr_ptr_reg, wr_ptr_next;
    logic [POINTER_WIDTH-1:0] rd_ptr_reg, rd_ptr_next;
    logic [LEVEL_WIDTH-1:0]   level_reg, level_next;
    logic                     overflow_reg, overflow_next;
    logic                     underflow_reg, underflow_next;
    logic                     wr_ok, rd_ok;

    fifo_flag_gen #(
        .FIFO_DEPTH  (FIFO_DEPTH),
        .LEVEL_WIDTH (LEVEL_WIDTH)
    ) u_flag_gen (
        .level        (level_reg),
        .af_thresh    (AF_Thresh),
        .ae_thresh    (AE_Thresh),
        .full         (Full),
        .empty        (Empty),
        .almost_full  (Almost_Full),
        .almost_empty (Almost_Empty)
    );

    assign wr_ok = Wr_Req && !Full;
    assign rd_ok = Rd_Req && !Empty;

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        level_next  = level_reg;
        if (wr_ok)
            wr_ptr_next = POINTER_WIDTH'(ptr_inc(32'(wr_ptr_reg), FIFO_DEPTH));
        if (rd_ok)
            rd_ptr_next = POINTER_WIDTH'(ptr_inc(32'(rd_ptr_reg), FIFO_DEPTH));
        if (wr_ok && !rd_ok)
            level_next = level_reg + LEVEL_WIDTH'(1);
        else if (!wr_ok && rd_ok)
            level_next = level_reg - LEVEL_WIDTH'(1);
        // A rejection in the same cycle as Clr_Err keeps the flag set.
        overflow_next  = (overflow_reg && !Clr_Err) || (Wr_Req && Full);
        underflow_next = (underflow_reg && !Clr_Err) || (Rd_Req && Empty);
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            level_reg     <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            wr_ptr_reg    <= wr_ptr_next;
            rd_ptr_reg    <= rd_ptr_next;
            level_reg     <= level_next;
            overflow_reg  <= overflow_next;
            underflow_reg <= underflow_next;
        end
    end

    always_ff @(posedge CLK) begin
        if (wr_ok)
            mem[wr_ptr_reg] <= D_IN;
    end

`ifdef SYNC_FIFO_FWFT_EN
    assign D_OUT      = mem[rd_ptr_reg];
    assign TX_D_Valid = !Empty;
`else
    logic [FIFO_WIDTH-1:0] dout_reg;
    logic                  valid_reg;

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            dout_reg  <= '0;
            valid_reg <= 1'b0;
        end else begin
            valid_reg <= rd_ok;
            if (rd_ok)
                dout_reg <= mem[rd_ptr_reg];
        end
    end

    assign D_OUT      = dout_reg;
    assign TX_D_Valid = valid_reg;
`endif

    assign Level     = level_reg;
    assign Overflow  = overflow_reg;
    assign Underflow = underflow_reg;

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Randomised bench for sync_fifo_flags (depth 5) against a queue-based reference model.
module tb_sync_fifo_flags;

    localparam int WIDTH = 8;
    localparam int DEPTH = 5;
    localparam int LW    = 3;

    logic             CLK;
    logic             rst_n;
    logic [WIDTH-1:0] D_IN;
    logic             Wr_Req, Rd_Req, Clr_Err;
    logic [LW-1:0]    AF_Thresh, AE_Thresh;
    logic [WIDTH-1:0] D_OUT;
    logic             TX_D_Valid, Full, Empty, Almost_Full, Almost_Empty;
    logic [LW-1:0]    Level;
    logic             Overflow, Underflow;

    sync_fifo_flags #(
        .FIFO_WIDTH (WIDTH),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .CLK          (CLK),
        .rst_n        (rst_n),
        .D_IN         (D_IN),
        .Wr_Req       (Wr_Req),
        .Rd_Req       (Rd_Req),
        .AF_Thresh    (AF_Thresh),
        .AE_Thresh    (AE_Thresh),
        .Clr_Err      (Clr_Err),
        .D_OUT        (D_OUT),
        .TX_D_Valid   (TX_D_Valid),
        .Full         (Full),
        .Empty        (Empty),
        .Almost_Full  (Almost_Full),
        .Almost_Empty (Almost_Empty),
        .Level        (Level),
        .Overflow     (Overflow),
        .Underflow    (Underflow)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Reference model: contents as a queue plus the visible registered outputs.
    logic [WIDTH-1:0] q[$];
    logic [WIDTH-1:0] m_dout  = '0;
    bit               m_valid = 1'b0;
    bit               m_ovf   = 1'b0;
    bit               m_unf   = 1'b0;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_dout  = '0;
        m_valid = 1'b0;
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
    endtask

    task automatic model_edge();
        int n;
        bit full, empty, wok, rok;
        n     = q.size();
        full  = (n == DEPTH);
        empty = (n == 0);
        wok   = Wr_Req && !full;
        rok   = Rd_Req && !empty;
        m_ovf = (m_ovf && !Clr_Err) || (Wr_Req && full);
        m_unf = (m_unf && !Clr_Err) || (Rd_Req && empty);
        m_valid = rok;
        if (rok) m_dout = q.pop_front();
        if (wok) q.push_back(D_IN);
    endtask

    task automatic step(input bit wr, input bit rd, input logic [WIDTH-1:0] d, input bit clr);
        Wr_Req  = wr;
        Rd_Req  = rd;
        D_IN    = d;
        Clr_Err = clr;
        @(posedge CLK);
        model_edge();
        #1;
        Wr_Req  = 1'b0;
        Rd_Req  = 1'b0;
        Clr_Err = 1'b0;
    endtask

    // Per-cycle comparison of every output against the model.
    initial begin
        forever begin
            @(negedge CLK);
            chk("level", 32'(Level), 32'(q.size()));
            chk("empty", 32'(Empty), 32'(q.size() == 0));
            chk("full", 32'(Full), 32'(q.size() == DEPTH));
            chk("almost_full", 32'(Almost_Full), 32'(32'(q.size()) >= 32'(AF_Thresh)));
            chk("almost_empty", 32'(Almost_Empty), 32'(32'(q.size()) <= 32'(AE_Thresh)));
            chk("overflow", 32'(Overflow), 32'(m_ovf));
            chk("underflow", 32'(Underflow), 32'(m_unf));
`ifdef SYNC_FIFO_FWFT_EN
            chk("tx_valid", 32'(TX_D_Valid), 32'(q.size() != 0));
            if (q.size() != 0)
                chk("d_out_head", 32'(D_OUT), 32'(q[0]));
`else
            chk("tx_valid", 32'(TX_D_Valid), 32'(m_valid));
            chk("d_out", 32'(D_OUT), 32'(m_dout));
`endif
        end
    end

    initial begin
        rst_n     = 1'b0;
        Wr_Req    = 1'b0;
        Rd_Req    = 1'b0;
        Clr_Err   = 1'b0;
        D_IN      = '0;
        AF_Thresh = 3'd4;
        AE_Thresh = 3'd1;
        model_reset();
        repeat (2) @(posedge CLK);
        #1 rst_n = 1'b1;
        chk("reset_level", 32'(Level), 32'd0);
        chk("reset_empty", 32'(Empty), 32'd1);
        chk("reset_full", 32'(Full), 32'd0);

        // Fill 0x11..0x15
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, 1'b0, 8'(8'h11 + i), 1'b0);
            $display("write %0h level=%0d", 8'h11 + i, Level);
            chk("fill_level", 32'(Level), 32'(i + 1));
            chk("fill_empty", 32'(Empty), 32'd0);
            if (i == 3) chk("fill_af_at4", 32'(Almost_Full), 32'd1);
            if (i == 3) chk("fill_notfull_at4", 32'(Full), 32'd0);
        end
        chk("fill_full", 32'(Full), 32'd1);

        // Overflow then clear
        step(1'b1, 1'b0, 8'hAA, 1'b0);
        $display("overflow write level=%0d ovf=%0b", Level, Overflow);
        chk("ovf_set", 32'(Overflow), 32'd1);
        chk("ovf_level", 32'(Level), 32'd5);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        chk("ovf_clr", 32'(Overflow), 32'd0);

        // Drain in order
        for (int i = 0; i < DEPTH; i++) begin
`ifdef SYNC_FIFO_FWFT_EN
            chk("fwft_head", 32'(D_OUT), 32'(8'h11 + i));
            chk("fwft_valid", 32'(TX_D_Valid), 32'd1);
            step(1'b0, 1'b1, 8'h00, 1'b0);
`else
            step(1'b0, 1'b1, 8'h00, 1'b0);
            chk("drain_data", 32'(D_OUT), 32'(8'h11 + i));
            chk("drain_valid", 32'(TX_D_Valid), 32'd1);
`endif
            $display("read %0h level=%0d", D_OUT, Level);
        end
        chk("drain_empty", 32'(Empty), 32'd1);
        step(1'b0, 1'b1, 8'h00, 1'b0);
        $display("underflow read unf=%0b valid=%0b", Underflow, TX_D_Valid);
        chk("unf_set", 32'(Underflow), 32'd1);
        chk("unf_valid", 32'(TX_D_Valid), 32'd0);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        chk("unf_clr", 32'(Underflow), 32'd0);

        // Full collision: write rejected, read accepted
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 8'(8'h31 + i), 1'b0);
        step(1'b1, 1'b1, 8'hBB, 1'b0);
        $display("full collision level=%0d ovf=%0b", Level, Overflow);
        chk("fullcol_level", 32'(Level), 32'd4);
        chk("fullcol_ovf", 32'(Overflow), 32'd1);
        // Clear in the same cycle as a new rejection: set wins
        step(1'b1, 1'b0, 8'h77, 1'b0);
        step(1'b1, 1'b0, 8'h78, 1'b1);
        chk("clr_vs_set", 32'(Overflow), 32'd1);
        step(1'b0, 1'b0, 8'h00, 1'b1);

        // Empty collision: read rejected, write accepted
        while (q.size() != 0) step(1'b0, 1'b1, 8'h00, 1'b0);
        step(1'b1, 1'b1, 8'hCC, 1'b0);
        $display("empty collision level=%0d unf=%0b", Level, Underflow);
        chk("emptycol_level", 32'(Level), 32'd1);
        chk("emptycol_unf", 32'(Underflow), 32'd1);
        step(1'b0, 1'b0, 8'h00, 1'b1);

        // Streaming around level 3 to exercise pointer wrap
        step(1'b1, 1'b0, 8'(8'h40), 1'b0);
        step(1'b1, 1'b0, 8'(8'h41), 1'b0);
        for (int i = 0; i < 100; i++) begin
            bit wr, rd;
            int r;
            r  = int'($urandom_range(0, 9));
            wr = (r < 8) || (q.size() < 3);
            rd = (r < 8) || (q.size() > 3);
            step(wr, rd, 8'($urandom), 1'b0);
            $display("stream wr=%0b rd=%0b level=%0d dout=%0h", wr, rd, Level, D_OUT);
        end

        // Fully random traffic with varying thresholds, including the degenerate ones
        for (int i = 0; i < 300; i++) begin
            if (i % 50 == 0) begin
                AF_Thresh = 3'($urandom_range(0, 7));
                AE_Thresh = 3'($urandom_range(0, 7));
            end
            step(1'($urandom), 1'($urandom), 8'($urandom), ($urandom_range(0, 9) == 0));
            $display("random level=%0d af=%0b ae=%0b ovf=%0b unf=%0b", Level, Almost_Full, Almost_Empty, Overflow, Underflow);
        end
        AF_Thresh = 3'd0;
        AE_Thresh = 3'd5;
        step(1'b0, 1'b0, 8'h00, 1'b0);
        chk("af_zero", 32'(Almost_Full), 32'd1);
        chk("ae_ge_depth", 32'(Almost_Empty), 32'd1);
        AF_Thresh = 3'd4;
        AE_Thresh = 3'd1;

        // Asynchronous reset between edges at level 3
        while (q.size() != 3) step(q.size() < 3, q.size() > 3, 8'($urandom), 1'b0);
        step(1'b0, 1'b1, 8'h00, 1'b0);
        step(1'b1, 1'b0, 8'h5A, 1'b0);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        $display("async reset level=%0d empty=%0b valid=%0b", Level, Empty, TX_D_Valid);
        chk("arst_level", 32'(Level), 32'd0);
        chk("arst_empty", 32'(Empty), 32'd1);
        chk("arst_valid", 32'(TX_D_Valid), 32'd0);
        @(posedge CLK);
        #1 rst_n = 1'b1;
        step(1'b1, 1'b0, 8'h66, 1'b0);
        step(1'b0, 1'b1, 8'h00, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
